// File: rtl/ysyx_220066_dmem_resp.sv
// rtl/ysyx_220066_dmem_resp.sv - data-memory responder for the ysyx_220066 M stage
//
// Accepts a held load/store request from the M stage, performs one 8-byte-aligned
// access on the backing memory port (req/ack) and returns extended load data.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   MemRd, MemWr      load / store request levels (held while block=1)
//   MemOp             RISC-V funct3 access size/sign
//   addr, data_Wr     byte address, right-aligned store data
//   block             pipeline stall (combinational from request inputs)
//   rdata             extended load result, held between loads
//   rdata_valid       one-cycle pulse when rdata updates
//   err               one-cycle pulse on bad or timed-out request
//   mem_req..mem_wdata  backing request, registered at acceptance
//   mem_rdata, mem_ack  backing read data and single-cycle completion
module ysyx_220066_dmem_resp #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic [2:0]  MemOp,
   input  logic [63:0] addr,
   input  logic [63:0] data_Wr,
   output logic        block,
   output logic [63:0] rdata,
   output logic        rdata_valid,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [7:0]  mem_wmask,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0] MAX_WAIT_U = 32'(MAX_WAIT);

   state_t      state;
   logic [2:0]  op_q;
   logic [2:0]  off_q;
   logic [7:0]  cnt;
   logic        err_q;

   logic        misalign;
   logic        bad;
   logic        accept;
   logic        reject;
   logic        timeout;
   logic [7:0]  size_mask;
   logic [63:0] rd_shifted;

   always_comb begin
      misalign  = 1'b0;
      size_mask = 8'h01;
      case (MemOp[1:0])
         2'b00: begin misalign = 1'b0;        size_mask = 8'h01; end
         2'b01: begin misalign = addr[0];     size_mask = 8'h03; end
         2'b10: begin misalign = |addr[1:0];  size_mask = 8'h0F; end
         default: begin misalign = |addr[2:0]; size_mask = 8'hFF; end
      endcase
   end

   // Unsigned-store opcodes (BU/HU/WU) have no store meaning, so they are rejected.
   assign bad    = (MemRd & MemWr) | (MemOp == 3'b111) | (MemWr & MemOp[2]) | misalign;
   assign accept = (state == IDLE) & (MemRd | MemWr) & ~bad;
   assign reject = (state == IDLE) & (MemRd | MemWr) & bad;

   // Timeout fires on the BUSY cycle whose count increment would reach MAX_WAIT,
   // so BUSY lasts exactly MAX_WAIT cycles when no ack arrives.
   assign timeout = (MAX_WAIT_U != 32'd0) && (({24'd0, cnt} + 32'd1) == MAX_WAIT_U);

   assign block = rst & ((state == BUSY) | accept);
   assign err   = err_q | (rst & reject);

   assign rd_shifted = mem_rdata >> {off_q, 3'b000};

   function automatic logic [63:0] extend(input logic [2:0] op, input logic [63:0] v);
      case (op)
         3'b000:  extend = {{56{v[7]}},  v[7:0]};
         3'b001:  extend = {{48{v[15]}}, v[15:0]};
         3'b010:  extend = {{32{v[31]}}, v[31:0]};
         3'b100:  extend = {56'd0, v[7:0]};
         3'b101:  extend = {48'd0, v[15:0]};
         3'b110:  extend = {32'd0, v[31:0]};
         default: extend = v;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         op_q        <= 3'd0;
         off_q       <= 3'd0;
         cnt         <= 8'd0;
         err_q       <= 1'b0;
         rdata       <= 64'd0;
         rdata_valid <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= 64'd0;
         mem_wmask   <= 8'd0;
         mem_wdata   <= 64'd0;
      end else begin
         rdata_valid <= 1'b0;
         err_q       <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q      <= MemOp;
                  off_q     <= addr[2:0];
                  cnt       <= 8'd0;
                  mem_req   <= 1'b1;
                  mem_we    <= MemWr;
                  mem_addr  <= {addr[63:3], 3'b000};
                  mem_wmask <= MemWr ? (size_mask << addr[2:0]) : 8'd0;
                  mem_wdata <= MemWr ? (data_Wr << {addr[2:0], 3'b000}) : 64'd0;
                  state     <= BUSY;
               end else if (reject) begin
                  // Park in DONE so the still-held bad request cannot re-fire.
                  state <= DONE;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (!mem_we) begin
                     rdata       <= extend(op_q, rd_shifted);
                     rdata_valid <= 1'b1;
                  end
                  state <= DONE;
               end else if (timeout) begin
                  mem_req <= 1'b0;
                  err_q   <= 1'b1;
                  state   <= DONE;
               end else if (cnt != 8'hFF) begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ysyx_220066_dmem_resp.md
# ysyx_220066_dmem_resp

Data-memory responder for the ysyx_220066 pipeline. It sits at the far end of the M-stage memory request interface. It accepts a registered load/store request (MemRd/MemWr, MemOp, addr, data_Wr), converts it into an 8-byte-aligned access on a backing memory port with a req/ack handshake, and returns aligned, sign/zero-extended load data. While an access is in flight it asserts `block`, which freezes the M stage and everything upstream.

## Interface

- `MAX_WAIT`, default 255: ack wait limit in cycles. Exceeding it aborts the access with `err`. 0 disables the timeout.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `MemRd`  in  1  load request, level, held stable by M stage while `block`=1
- `MemWr`  in  1  store request, same rules as `MemRd`
- `MemOp`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal
- `addr`  in  64  byte address
- `data_Wr`  in  64  store data, right-aligned
- `block`  out  1  stall to pipeline
- `rdata`  out  64  extended load result
- `rdata_valid`  out  1  one-cycle pulse: `rdata` updated this cycle
- `err`  out  1  one-cycle pulse: misaligned, illegal, conflicting or timed-out request
- `mem_req`  out  1  backing request, held until `mem_ack`
- `mem_we`  out  1  1 = write
- `mem_addr`  out  64  `{addr[63:3],3'b0}`
- `mem_wmask`  out  8  byte-lane enables
- `mem_wdata`  out  64  lane-shifted store data
- `mem_rdata`  in  64  read data, valid with `mem_ack`
- `mem_ack`  in  1  backing completion, single-cycle

## Operation

**Request check.** A request is `MemRd|MemWr`, evaluated in IDLE only. It is *bad* if any of the following hold:
- `MemRd&MemWr`
- `MemOp`=111
- store with `MemOp[2]`=1
- size misaligned: H needs `addr[0]`=0; W needs `addr[1:0]`=0; D needs `addr[2:0]`=0

**Bad request.** No backing access is made. `err`=1 combinationally that cycle, `block`=0, and the FSM enters DONE. This prevents the same held request from re-firing.

**Good request.** In the same cycle the block captures `MemOp`, `addr[2:0]` and `we` into registers, drives `mem_req`=1, and moves to BUSY. `block`=1 combinationally in that IDLE cycle.

**FSM states:**
- IDLE: on good request → BUSY; on bad request → DONE; otherwise stay.
- BUSY: `mem_req`=1, `block`=1. On `mem_ack` → DONE. If the counter reaches `MAX_WAIT` → DONE with `err` pulse and no `rdata_valid`.
- DONE: `block`=0 and `mem_req`=0. Unconditionally → IDLE. The M stage latches its next request at this edge.

**Write path.**
- `mem_wmask` = (B:0x01, H:0x03, W:0x0F, D:0xFF) << `addr[2:0]`
- `mem_wdata` = `data_Wr` << (8·`addr[2:0]`)
- For loads, `mem_wmask`=0.
- `mem_addr`, `mem_we`, `mem_wmask` and `mem_wdata` are registered at acceptance and stable throughout BUSY.

**Read path.**
- On `mem_ack` in BUSY for a load, `rdata` is registered as `mem_rdata` >> (8·off), then:
  - sign-extended from bit 7/15/31 for B/H/W;
  - zero-extended for BU/HU/WU;
  - unchanged for D.
- `rdata_valid` pulses in DONE.
- A store ack produces `rdata_valid`=0 and leaves `rdata` unchanged.
- `rdata` holds its value between loads.

**Other rules.**
- A `mem_ack` received outside BUSY is ignored.
- The wait counter is 8 bits wide, is cleared on entry to BUSY, and saturates.

## Timing

- Reset (`rst`=0 at a clock edge) sets: state IDLE, `mem_req`=0, `mem_we`=0, `mem_wmask`=0, `mem_addr`=0, `mem_wdata`=0, `rdata`=0, `rdata_valid`=0, `err`=0, counter=0.
- `block` is also 0 during reset, because it is gated by `rst`.
- Reset during BUSY drops `mem_req` on the next edge. A late ack is then ignored.
- With ack k cycles after the first `mem_req` cycle (k≥1), `block` is high for k+1 cycles: the acceptance cycle plus k.
- `rdata_valid` and `err` are asserted in the DONE cycle, which is the cycle `block` falls. The exception is a bad request, whose `err` is asserted in the request cycle.
- Back-to-back accesses have a minimum spacing of 3 cycles: IDLE→BUSY→DONE with k=1.
- `block` may depend combinationally on `MemRd`, `MemWr`, `MemOp` and `addr`. No other output is combinational from inputs.

## Test plan

- LB: `addr`=0x1003, `mem_rdata`=0x00000000_80000000 (byte at lane 3 = 0x80), ack after 2 cycles → `block` high for 3 cycles, `rdata`=0xFFFFFFFF_FFFFFF80, `rdata_valid` pulse, `mem_addr`=0x1000.
- LWU: `addr`=0x2004, `mem_rdata`=0x89ABCDEF_00000000 → `rdata`=0x00000000_89ABCDEF. LD: `addr`=0x8 → `rdata`=`mem_rdata` unchanged.
- SH: `addr`=0x3006, `data_Wr`=0x1234 → `mem_wmask`=0xC0, `mem_wdata`=0x1234_0000_0000_0000, `mem_we`=1, and `rdata` is unchanged.
- Misaligned SW at `addr`=0x4002 → same-cycle `err`=1, `block`=0, no `mem_req`. One DONE cycle follows, then a new request is accepted.
- Timeout with `MAX_WAIT`=4 and `mem_ack` never asserted → `mem_req` drops and `err` pulses 5 cycles after acceptance. A late ack is ignored and causes no `rdata_valid`.
- `rst`=0 asserted mid-BUSY → all outputs reach their reset values next cycle. After reset release, a fresh LD completes normally.
